// File: rtl/led_seq_if.sv
// led_seq_if: button/direction inputs and LED/mode status of the LED sequencer
interface led_seq_if;
   logic       btn_step;
   logic       btn_mode;
   logic       dir;
   logic [2:0] led_out;
   logic [1:0] mode;
   logic       step_pulse;
   modport master(output btn_step, btn_mode, dir, input led_out, mode, step_pulse);
   modport slave(input btn_step, btn_mode, dir, output led_out, mode, step_pulse);
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: debounced-button one-hot LED sequencer with MANUAL/AUTO/HOLD modes
module led_seq_ctrl #(
   parameter int DEB_CYCLES  = 4,
   parameter int AUTO_PERIOD = 8
) (
   input  logic      clk,
   input  logic      rst,
   led_seq_if.slave  io
);
   typedef enum logic [1:0] {MANUAL = 2'b00, AUTO = 2'b01, HOLD = 2'b10} mode_t;
   logic [1:0]  s1_q, s2_q, deb_q, debp_q, press;
   logic [7:0]  cnt_q [2];
   mode_t       mode_q, mode_d;
   logic [2:0]  led_q, led_d;
   logic [15:0] per_q, per_d;
   logic        sp_q, tc, adv;
   // bit 0 is the step button, bit 1 the mode button
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         deb_q  <= '0;
         debp_q <= '0;
         cnt_q  <= '{default: '0};
      end else begin
         s1_q   <= {io.btn_mode, io.btn_step};
         s2_q   <= s1_q;
         debp_q <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == deb_q[i]) cnt_q[i] <= '0;
            else if (cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
               deb_q[i] <= ~deb_q[i];
               cnt_q[i] <= '0;
            end else cnt_q[i] <= cnt_q[i] + 8'd1;
         end
      end
   end
   assign press = deb_q & ~debp_q;
   // a mode press wins over any step in the same cycle
   always_comb begin
      tc     = mode_q == AUTO && per_q == 16'(AUTO_PERIOD - 1);
      adv    = !press[1] && ((mode_q == MANUAL && press[0]) || tc);
      mode_d = !press[1] ? mode_q : mode_q == MANUAL ? AUTO : mode_q == AUTO ? HOLD : MANUAL;
      led_d  = !$onehot(led_q) ? 3'b001 : !adv ? led_q :
               io.dir ? {led_q[0], led_q[2:1]} : {led_q[1:0], led_q[2]};
      per_d  = (mode_q != AUTO || mode_d != AUTO || tc) ? '0 : per_q + 16'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= MANUAL;
         led_q  <= 3'b001;
         per_q  <= '0;
         sp_q   <= 1'b0;
      end else begin
         mode_q <= mode_d;
         led_q  <= led_d;
         per_q  <= per_d;
         sp_q   <= led_d != led_q;
      end
   end
   assign io.led_out    = led_q;
   assign io.mode       = mode_q;
   assign io.step_pulse = sp_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed checks of debounce timing, stepping, modes and reset
module tb_led_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic seen;
   led_seq_if bus();
   led_seq_ctrl #(.DEB_CYCLES(4), .AUTO_PERIOD(8)) dut (.clk(clk), .rst(rst), .io(bus));
   always #5 clk = ~clk;
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic press(input bit mode_btn);
      if (mode_btn) bus.btn_mode = 1'b1; else bus.btn_step = 1'b1;
      tick(8);
      bus.btn_mode = 1'b0;
      bus.btn_step = 1'b0;
      tick(8);
   endtask
   initial begin
      bus.btn_step = 1'b0;
      bus.btn_mode = 1'b0;
      bus.dir = 1'b0;
      tick(2);
      rst = 1'b0;
      chk("rst_led", 16'(bus.led_out), 16'h1);
      chk("rst_mode", 16'(bus.mode), 16'h0);
      chk("rst_sp", 16'(bus.step_pulse), 16'h0);
      bus.btn_step = 1'b1;
      tick(6);
      chk("deb_k5_led", 16'(bus.led_out), 16'h1);
      tick(1);
      chk("deb_k6_led", 16'(bus.led_out), 16'h2);
      chk("deb_k6_sp", 16'(bus.step_pulse), 16'h1);
      tick(1);
      chk("deb_k7_sp", 16'(bus.step_pulse), 16'h0);
      tick(10);
      bus.btn_step = 1'b0;
      tick(8);
      chk("held_once", 16'(bus.led_out), 16'h2);
      seen = 1'b0;
      bus.btn_step = 1'b1;
      tick(3);
      bus.btn_step = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen |= bus.step_pulse;
         tick(1);
      end
      chk("glitch_led", 16'(bus.led_out), 16'h2);
      chk("glitch_sp", 16'(seen), 16'h0);
      bus.dir = 1'b1;
      press(1'b0);
      chk("rev_010", 16'(bus.led_out), 16'h1);
      press(1'b0);
      chk("rev_001", 16'(bus.led_out), 16'h4);
      seen = 1'b0;
      bus.dir = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         seen |= bus.step_pulse;
      end
      chk("dir_only_led", 16'(bus.led_out), 16'h4);
      chk("dir_only_sp", 16'(seen), 16'h0);
      press(1'b0);
      chk("fwd_wrap", 16'(bus.led_out), 16'h1);
      bus.dir = 1'b1;
      bus.btn_step = 1'b1;
      bus.btn_mode = 1'b1;
      tick(7);
      chk("simul_mode", 16'(bus.mode), 16'h1);
      chk("simul_led", 16'(bus.led_out), 16'h1);
      chk("simul_sp", 16'(bus.step_pulse), 16'h0);
      tick(7);
      chk("auto_e7", 16'(bus.led_out), 16'h1);
      tick(1);
      chk("auto_e8", 16'(bus.led_out), 16'h4);
      chk("auto_e8_sp", 16'(bus.step_pulse), 16'h1);
      bus.btn_step = 1'b0;
      bus.btn_mode = 1'b0;
      tick(8);
      chk("auto_e16", 16'(bus.led_out), 16'h2);
      bus.btn_step = 1'b1;
      tick(7);
      chk("auto_step_ign", 16'(bus.led_out), 16'h2);
      tick(1);
      chk("auto_e24", 16'(bus.led_out), 16'h1);
      bus.btn_step = 1'b0;
      tick(8);
      chk("auto_e32", 16'(bus.led_out), 16'h4);
      tick(5);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_led", 16'(bus.led_out), 16'h1);
      chk("mid_rst_mode", 16'(bus.mode), 16'h0);
      chk("mid_rst_sp", 16'(bus.step_pulse), 16'h0);
      rst = 1'b0;
      tick(20);
      chk("post_rst_led", 16'(bus.led_out), 16'h1);
      chk("post_rst_mode", 16'(bus.mode), 16'h0);
      press(1'b1);
      chk("mode_auto", 16'(bus.mode), 16'h1);
      chk("auto_first", 16'(bus.led_out), 16'h4);
      press(1'b1);
      chk("mode_hold", 16'(bus.mode), 16'h2);
      chk("tc_vs_mode", 16'(bus.led_out), 16'h4);
      press(1'b0);
      chk("hold_step_ign", 16'(bus.led_out), 16'h4);
      press(1'b1);
      chk("mode_manual", 16'(bus.mode), 16'h0);
      chk("manual_led", 16'(bus.led_out), 16'h4);
      press(1'b0);
      chk("manual_rev", 16'(bus.led_out), 16'h2);
      bus.btn_step = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("requal_rst", 16'(bus.led_out), 16'h1);
      tick(6);
      chk("requal_k5", 16'(bus.led_out), 16'h1);
      tick(1);
      chk("requal_k6", 16'(bus.led_out), 16'h4);
      bus.btn_step = 1'b0;
      tick(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
